instr_fetch_queue: RTL

//  Fetch stage directly downstream of the PC logic. It owns the fetch address and issues

---
 rtl/ifq_pkg.sv | 21 ++
 rtl/ifq_fifo.sv | 82 ++++++++
 rtl/instr_fetch_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the instruction fetch queue.
//   ifq_entry_t : one decoded-side queue entry, {pc, inst}. The top level stores
//                 entries as a flat {pc, inst} vector with the same bit layout.
//   PC_STEP     : fetch address increment between sequential words.
//   INSTR_NOP   : canonical no-op encoding for consumers that need a filler word.
// ----------------------------------------------------------------------------
package ifq_pkg;

   localparam int IFQ_DW = 32;

   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [IFQ_DW-1:0] pc;
      logic [IFQ_DW-1:0] inst;
   } ifq_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// ----------------------------------------------------------------------------
// ifq_fifo
// Parameterised circular buffer used for both the instruction queue and the
// PC tag FIFO. Pointers carry one extra wrap bit so full and empty are
// distinguishable without a separate counter.
// Ports:
//   clk, rst        clock, asynchronous active-low reset (storage cleared too)
//   flush           drop all entries (wins over push/pop in the same cycle)
//   push, din       write din at the tail (ignored when full)
//   pop             advance the head (ignored when empty)
//   head            entry at the head (registered storage)
//   count           number of valid entries
//   full, empty     occupancy flags
// ----------------------------------------------------------------------------
module ifq_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] CNT_DEPTH = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic [AW:0]      count_s;
   logic             do_push_s;
   logic             do_pop_s;

   // Occupancy flags and guarded push/pop enables.
   always_comb begin
      count_s   = wr_ptr_r - rd_ptr_r;
      full      = (count_s == CNT_DEPTH);
      empty     = (wr_ptr_r == rd_ptr_r);
      count     = count_s;
      head      = mem_r[rd_ptr_r[AW-1:0]];
      do_push_s = push && !full;
      do_pop_s  = pop && !empty;
   end

   // Entry storage; a write during a flush is harmless because the pointers reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
   end

   // Read/write pointers; flush empties the buffer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage: owns the fetch PC, issues sequential word requests to
// instruction memory (req/gnt + in-order rvalid), buffers returned words with
// their PC and presents them to decode with valid/ready. A redirect flushes
// the queue and discards every response still in flight.
// Optional build macro: IFQ_BYPASS_EN -- when the queue is empty a live
// response is presented to decode in the same cycle it arrives.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   redirect_valid, redirect_pc     branch/jump target for the fetch PC
//   imem_req, imem_addr             request valid and fetch address
//   imem_gnt                        request accepted
//   imem_rvalid, imem_rdata         in-order response
//   inst_valid, inst_ready          decode handshake
//   inst, inst_pc                   head instruction and its PC
// ----------------------------------------------------------------------------
module instr_fetch_queue
   import ifq_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = {DATA_WIDTH{1'b0}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  inst_valid,
   input  logic                  inst_ready,
   output logic [DATA_WIDTH-1:0] inst,
   output logic [DATA_WIDTH-1:0] inst_pc
);

   localparam int                    CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]         CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW:0]           DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [DATA_WIDTH-1:0] STEP_C  = DATA_WIDTH'(PC_STEP);

   logic [DATA_WIDTH-1:0]   fetch_pc_r;
   logic [CW-1:0]           outstanding_r;
   logic [CW-1:0]           drop_cnt_r;

   // Queue entries use the ifq_entry_t layout: {pc, inst}.
   logic [2*DATA_WIDTH-1:0] q_din_s;
   logic [2*DATA_WIDTH-1:0] q_head_s;
   logic [CW-1:0]           q_count_s;
   logic                    q_full_s;
   logic                    q_empty_s;
   logic                    q_push_s;
   logic                    q_pop_s;

   logic [DATA_WIDTH-1:0]   tag_head_s;
   logic [CW-1:0]           tag_count_s;
   logic                    tag_full_s;
   logic                    tag_empty_s;

   logic                    credit_ok_s;
   logic                    req_s;
   logic                    grant_s;
   logic                    resp_live_s;
   logic                    resp_drop_s;
   logic                    bypass_s;
   logic                    bypass_take_s;
   logic [CW-1:0]           grant_cnt_s;
   logic [CW-1:0]           resp_cnt_s;
   logic                    unused_s;

   // Request credit, response classification, bypass and queue control.
   always_comb begin
      // In-flight requests reserve queue slots, so the queue can never overflow.
      credit_ok_s = (({1'b0, q_count_s} + {1'b0, outstanding_r}) < DEPTH_C);
      // Held low during reset so the request line shows its reset value.
      req_s       = rst && !redirect_valid && credit_ok_s;
      grant_s     = req_s && imem_gnt;
      resp_live_s = imem_rvalid && (drop_cnt_r == {CW{1'b0}});
      resp_drop_s = imem_rvalid && (drop_cnt_r != {CW{1'b0}});
      grant_cnt_s = {{(CW-1){1'b0}}, grant_s};
      resp_cnt_s  = {{(CW-1){1'b0}}, imem_rvalid};
`ifdef IFQ_BYPASS_EN
      bypass_s    = q_empty_s && resp_live_s;
`else
      bypass_s    = 1'b0;
`endif
      bypass_take_s = bypass_s && inst_ready;
      q_push_s      = resp_live_s && !bypass_take_s;
      q_pop_s       = !q_empty_s && inst_ready;
      q_din_s       = {tag_head_s, imem_rdata};
   end

   // Decode-facing outputs: bypassed response or registered queue head.
   always_comb begin
      if (bypass_s) begin
         inst_valid = 1'b1;
         inst       = imem_rdata;
         inst_pc    = tag_head_s;
      end else begin
         inst_valid = !q_empty_s;
         inst       = q_head_s[DATA_WIDTH-1:0];
         inst_pc    = q_head_s[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      imem_req  = req_s;
      imem_addr = fetch_pc_r;
   end

   // Fetch PC, outstanding-request and drop counters; redirect takes priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r    <= RESET_PC;
         outstanding_r <= {CW{1'b0}};
         drop_cnt_r    <= {CW{1'b0}};
      end else if (redirect_valid) begin
         // Everything still in flight after this cycle's response belongs to the old path.
         fetch_pc_r    <= redirect_pc;
         outstanding_r <= outstanding_r - resp_cnt_s;
         drop_cnt_r    <= outstanding_r - resp_cnt_s;
      end else begin
         if (grant_s) begin
            fetch_pc_r <= fetch_pc_r + STEP_C;
         end
         outstanding_r <= outstanding_r + grant_cnt_s - resp_cnt_s;
         if (resp_drop_s) begin
            drop_cnt_r <= drop_cnt_r - CNT_ONE;
         end
      end
   end

   ifq_fifo #(
      .WIDTH (2*DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_inst_q (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (q_push_s),
      .pop   (q_pop_s),
      .din   (q_din_s),
      .head  (q_head_s),
      .count (q_count_s),
      .full  (q_full_s),
      .empty (q_empty_s)
   );

   // Tags are flushed on redirect, so dropped responses have no tag left to
   // consume; only live responses pop a tag.
   ifq_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_valid),
      .push  (grant_s),
      .pop   (resp_live_s),
      .din   (fetch_pc_r),
      .head  (tag_head_s),
      .count (tag_count_s),
      .full  (tag_full_s),
      .empty (tag_empty_s)
   );

   assign unused_s = ^{q_full_s, tag_count_s, tag_full_s, tag_empty_s};

endmodule
